// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter: FSM states, beat counter width, index width.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int BEAT_W = 8;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping; purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  start;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotate so that bit 0 of 'rot' is the producer right after the last grant.
  assign start   = (last == IW'(N - 1)) ? '0 : last + IW'(1);
  assign req_dbl = {req, req};
  assign rot     = req_dbl[start +: N];

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum = {1'b0, start} + {1'b0, off};
  assign idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
  assign any = |req;

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locked sharing of one FIFO write port; beats pass combinationally in the grant cycle.
// One idle arbitration cycle per grant; fifo_full stalls the granted producer via req_ready, never overflows.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_shift_in,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [IW-1:0]                 grant_id,
  output logic [BEAT_W-1:0]             beat_cnt
);

  arb_state_e    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          pick_any;
  logic          in_grant;
  logic          beat;
  logic          burst_end;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick)
  );

  assign in_grant      = (state == ARB_GRANT);
  assign beat          = in_grant && req_valid[grant_id] && !fifo_full;
  assign burst_end     = beat && (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign fifo_shift_in = beat;
  assign grant_valid   = in_grant;

  always_comb begin
    req_ready = '0;
    fifo_din  = '0;
    if (in_grant) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == IW'(i)) begin
          req_ready[i] = !fifo_full;
          fifo_din     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state    <= ARB_GRANT;
            grant_id <= pick;
            beat_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          // A stalled but still-valid producer keeps the grant indefinitely.
          if (!req_valid[grant_id] || burst_end) begin
            state      <= ARB_IDLE;
            last_grant <= grant_id;
            beat_cnt   <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_shift_in && fifo_full));

endmodule
